// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the data cache arrays and cache_sram.
//   - Cache geometry (line size, line count, index/offset widths).
//   - Widths of the three array flavours: dirty, tag+valid, data bank.
//   - State type of the optional power-up clear engine.
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int LINE_SIZE  = 16;
    localparam int LINE_NUM   = 256;
    localparam int INDEX_LOG  = 8;
    localparam int OFFSET_LOG = 2;

    localparam int TAGV_W     = 21;  // 20-bit tag + valid bit
    localparam int DIRTY_W    = 1;
    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;

    // Clear engine: sweeping the array, or finished and array usable.
    typedef enum logic {
        CLR_RUN  = 1'b0,
        CLR_DONE = 1'b1
    } clr_state_e;

    // Width of one write-enable lane.
    function automatic int lane_width(input int data_w, input int we_w);
        return data_w / we_w;
    endfunction

endpackage

// File: rtl/cache_sram_if.sv
// -----------------------------------------------------------------------------
// cache_sram_if
// Access bus of one cache_sram instance (vendor block-RAM port shape).
//   ena       : port enable, one access per cycle while high
//   wea       : per-lane write enables, only meaningful with ena
//   addra     : word address
//   dina      : write data
//   douta     : registered read data (write-first)
//   init_done : array usable
//
// Handshake: there is no back-pressure. The array accepts an access on every
// rising edge where ena=1 and init_done=1; the result appears on douta one
// edge later and holds until the next accepted access. Requests presented
// while init_done=0 are dropped, not queued.
// -----------------------------------------------------------------------------
interface cache_sram_if
    import cache_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = INDEX_LOG,
    parameter int WE_W   = BYTE_LANES
);

    logic              ena;
    logic [WE_W-1:0]   wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              init_done;

    modport master (
        output ena, wea, addra, dina,
        input  douta, init_done
    );

    modport slave (
        input  ena, wea, addra, dina,
        output douta, init_done
    );

endinterface

// File: rtl/cache_sram_clear.sv
// -----------------------------------------------------------------------------
// cache_sram_clear
// Power-up clear engine: after reset release it walks addresses
// 0..2**ADDR_W-1, one per cycle, then parks in CLR_DONE for good.
// Only compiled when CACHE_SRAM_RESET_CLEAR_EN is defined.
//   clka    : clock
//   rst     : asynchronous active-low reset, restarts the sweep from 0
//   addr_o  : address being cleared this cycle (valid in CLR_RUN)
//   state_o : engine state, CLR_DONE means the array is usable
// -----------------------------------------------------------------------------
`ifdef CACHE_SRAM_RESET_CLEAR_EN
module cache_sram_clear
    import cache_pkg::*;
#(
    parameter int ADDR_W = INDEX_LOG
) (
    input  logic              clka,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr_o,
    output clr_state_e        state_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q <= CLR_RUN;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            CLR_RUN: begin
                addr_d = addr_q + ADDR_W'(1);
                // The last address is written on this edge; usable afterwards.
                if (addr_q == '1) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                state_d = CLR_DONE;
            end
            default: begin
                state_d = CLR_RUN;
                addr_d  = '0;
            end
        endcase
    end

    assign addr_o  = addr_q;
    assign state_o = state_q;

endmodule
`endif

// File: rtl/cache_sram.sv
// -----------------------------------------------------------------------------
// cache_sram
// Single-port synchronous RAM with per-lane write enables, write-first read
// data and 1-cycle read latency. One instance per cache array (dirty,
// tag+valid, data bank).
//   clka : clock, all activity on the rising edge
//   rst  : asynchronous active-low reset; clears douta, drops the write at
//          any edge where it is low
//   bus  : cache_sram_if slave (ena, wea, addra, dina, douta, init_done)
// Optional build macro CACHE_SRAM_RESET_CLEAR_EN: zero the whole array after
// reset through cache_sram_clear; init_done stays low until the sweep ends.
// Without it init_done is tied high and contents start undefined.
// DATA_W must be a multiple of WE_W.
// -----------------------------------------------------------------------------
module cache_sram
    import cache_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = INDEX_LOG,
    parameter int WE_W   = BYTE_LANES
) (
    input  logic       clka,
    input  logic       rst,
    cache_sram_if.slave bus
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANE_W = lane_width(DATA_W, WE_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] douta_q;

    // Unified array write port: either the user access or the clear engine.
    logic              acc_en;     // user access accepted, douta updates
    logic [WE_W-1:0]   lane_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              init_done;

`ifdef CACHE_SRAM_RESET_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
    clr_state_e        clr_state;

    cache_sram_clear #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clka    (clka),
        .rst     (rst),
        .addr_o  (clr_addr),
        .state_o (clr_state)
    );

    assign init_done = (clr_state == CLR_DONE);

    always_comb begin
        acc_en    = 1'b0;
        lane_we   = '0;
        mem_addr  = bus.addra;
        mem_wdata = bus.dina;
        if (!init_done) begin
            // Sweep owns the port; user requests are ignored, douta stays 0.
            lane_we   = '1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
        end else if (bus.ena) begin
            acc_en  = 1'b1;
            lane_we = bus.wea;
        end
    end
`else
    assign init_done = 1'b1;

    always_comb begin
        acc_en    = 1'b0;
        lane_we   = '0;
        mem_addr  = bus.addra;
        mem_wdata = bus.dina;
        // wea and a possibly unknown addra are harmless while ena is low.
        if (bus.ena) begin
            acc_en  = 1'b1;
            lane_we = bus.wea;
        end
    end
`endif

    // Array and read register share one process so that an edge seen with
    // rst low neither writes the array nor updates douta. The array itself
    // is never reset.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            douta_q <= '0;
        end else begin
            for (int k = 0; k < WE_W; k++) begin
                if (lane_we[k]) begin
                    mem[mem_addr][k*LANE_W +: LANE_W] <= mem_wdata[k*LANE_W +: LANE_W];
                end
                // Write-first: written lanes return new data, others old data.
                if (acc_en) begin
                    douta_q[k*LANE_W +: LANE_W] <= lane_we[k]
                        ? mem_wdata[k*LANE_W +: LANE_W]
                        : mem[mem_addr][k*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign bus.douta     = douta_q;
    assign bus.init_done = init_done;

endmodule

// File: tb/tb_cache_sram.sv
// -----------------------------------------------------------------------------
// tb_cache_sram
// Bench for cache_sram in three shapes: 32-bit data bank with byte lanes,
// 21-bit tag+valid array and 1-bit dirty array. Works with or without
// CACHE_SRAM_RESET_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_cache_sram;
    import cache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_sram_if #(.DATA_W(32), .ADDR_W(8), .WE_W(4)) b32 ();
    cache_sram_if #(.DATA_W(21), .ADDR_W(8), .WE_W(1)) b21 ();
    cache_sram_if #(.DATA_W(1),  .ADDR_W(8), .WE_W(1)) b1  ();

    cache_sram #(.DATA_W(32), .ADDR_W(8), .WE_W(4)) u_data  (.clka(clk), .rst(rst_n), .bus(b32));
    cache_sram #(.DATA_W(21), .ADDR_W(8), .WE_W(1)) u_tagv  (.clka(clk), .rst(rst_n), .bus(b21));
    cache_sram #(.DATA_W(1),  .ADDR_W(8), .WE_W(1)) u_dirty (.clka(clk), .rst(rst_n), .bus(b1));

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        ena;
        logic [3:0]  wea;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Behavioural reference: array of words, lanes merged byte by byte.
    logic [31:0] ref_mem [256];
    logic [31:0] ref_dout;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drv32(input logic e, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
        b32.ena   = e;
        b32.wea   = w;
        b32.addra = a;
        b32.dina  = d;
    endtask

    task automatic drv21(input logic e, input logic w, input logic [7:0] a, input logic [20:0] d);
        b21.ena   = e;
        b21.wea   = w;
        b21.addra = a;
        b21.dina  = d;
    endtask

    task automatic drv1(input logic e, input logic w, input logic [7:0] a, input logic d);
        b1.ena   = e;
        b1.wea   = w;
        b1.addra = a;
        b1.dina  = d;
    endtask

    task automatic idle_all();
        drv32(1'b0, 4'h0, 8'h00, 32'h0);
        drv21(1'b0, 1'b0, 8'h00, 21'h0);
        drv1(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Waits for the clear sweep (bounded) and returns the edges it took.
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (b32.init_done !== 1'b1 && cnt < 400) begin
            cycle();
            cnt++;
        end
    endtask

    // One 32-bit access checked against the reference model.
    task automatic op32(input string name, input logic e, input logic [3:0] w,
                        input logic [7:0] a, input logic [31:0] d);
        if (e) begin
            for (int b = 0; b < 4; b++) begin
                if (w[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end
            ref_dout = ref_mem[a];
        end
        exp_q.push_back(ref_dout);
        drv32(e, w, a, d);
        cycle();
        check(name, b32.douta, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        idle_all();

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_douta", b32.douta, 32'h0);
        repeat (3) cycle();
        check("rst_douta32", b32.douta, 32'h0);
        check("rst_douta21", 32'(b21.douta), 32'h0);
        check("rst_douta1", 32'(b1.douta), 32'h0);
`ifdef CACHE_SRAM_RESET_CLEAR_EN
        check("rst_init_done", 32'(b32.init_done), 32'h0);
        rst_n = 1'b1;
        // Requests during the sweep must be ignored.
        drv32(1'b1, 4'hF, 8'h00, 32'hFFFF_FFFF);
        wait_init(cnt);
        check("init_cycles", 32'(cnt), 32'd256);
        check("init_douta", b32.douta, 32'h0);
        check("init_done21", 32'(b21.init_done), 32'h1);
        drv32(1'b1, 4'h0, 8'h7F, 32'h0);
        cycle();
        check("init_rd7f", b32.douta, 32'h0);
        drv32(1'b1, 4'h0, 8'h00, 32'h0);
        cycle();
        check("init_rd00", b32.douta, 32'h0);
        drv21(1'b1, 1'b0, 8'h33, 21'h0);
        cycle();
        check("init_rd21", 32'(b21.douta), 32'h0);
        drv21(1'b0, 1'b0, 8'h00, 21'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
`else
        rst_n = 1'b1;
        check("init_done", 32'(b32.init_done), 32'h1);
        check("init_douta", b32.douta, 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hx;
`endif
        drv32(1'b0, 4'h0, 8'h00, 32'h0);
        cycle();

        // ---------------- table-driven vectors ----------------
        vecs.push_back('{1'b1, 4'hF, 8'h12, 32'hDEAD_BEEF, 32'hDEAD_BEEF}); // full write, write-first
        vecs.push_back('{1'b1, 4'h0, 8'h12, 32'h0,         32'hDEAD_BEEF}); // readback
        vecs.push_back('{1'b1, 4'h5, 8'h12, 32'h1122_3344, 32'hDE22_BE44}); // lane merge
        vecs.push_back('{1'b1, 4'h0, 8'h12, 32'hFFFF_FFFF, 32'hDE22_BE44});
        vecs.push_back('{1'b0, 4'hF, 8'h12, 32'h0000_0000, 32'hDE22_BE44}); // hold on disable
        vecs.push_back('{1'b0, 4'hF, 8'hED, 32'hFFFF_FFFF, 32'hDE22_BE44});
        vecs.push_back('{1'b0, 4'h3, 8'h12, 32'h5555_5555, 32'hDE22_BE44});
        vecs.push_back('{1'b0, 4'hF, 8'hxx, 32'hAAAA_AAAA, 32'hDE22_BE44});
        vecs.push_back('{1'b0, 4'hx, 8'h00, 32'h1234_5678, 32'hDE22_BE44});
        vecs.push_back('{1'b1, 4'h0, 8'h12, 32'h0,         32'hDE22_BE44}); // memory unchanged
        vecs.push_back('{1'b1, 4'hA, 8'h12, 32'hAABB_CCDD, 32'hAA22_CC44}); // upper/odd lanes
        vecs.push_back('{1'b1, 4'hF, 8'h13, 32'h0BAD_F00D, 32'h0BAD_F00D});
        vecs.push_back('{1'b1, 4'h0, 8'h12, 32'h0,         32'hAA22_CC44});
        vecs.push_back('{1'b1, 4'h0, 8'h13, 32'h0,         32'h0BAD_F00D});
        foreach (vecs[i]) begin
            drv32(vecs[i].ena, vecs[i].wea, vecs[i].addr, vecs[i].din);
            exp_q.push_back(vecs[i].exp);
            cycle();
            check($sformatf("vec%0d", i), b32.douta, exp_q.pop_front());
        end
        drv32(1'b0, 4'h0, 8'h00, 32'h0);

        // ---------------- narrow configurations ----------------
        drv21(1'b1, 1'b1, 8'h00, 21'h000123); cycle(); check("t21_wr00", 32'(b21.douta), 32'h000123);
        drv21(1'b1, 1'b1, 8'hFF, 21'h1ABCDE); cycle(); check("t21_wrff", 32'(b21.douta), 32'h1ABCDE);
        drv21(1'b1, 1'b0, 8'h00, 21'h1FFFFF); cycle(); check("t21_rd00", 32'(b21.douta), 32'h000123);
        drv21(1'b1, 1'b0, 8'hFF, 21'h0);      cycle(); check("t21_rdff", 32'(b21.douta), 32'h1ABCDE);
        drv21(1'b0, 1'b0, 8'h00, 21'h0);
        drv1(1'b1, 1'b1, 8'h05, 1'b1); cycle(); check("d1_wr1", 32'(b1.douta), 32'h1);
        drv1(1'b1, 1'b0, 8'h05, 1'b0); cycle(); check("d1_rd1", 32'(b1.douta), 32'h1);
        drv1(1'b1, 1'b1, 8'h05, 1'b0); cycle(); check("d1_wr0", 32'(b1.douta), 32'h0);
        drv1(1'b0, 1'b1, 8'h05, 1'b1); cycle(); check("d1_hold", 32'(b1.douta), 32'h0);
        drv1(1'b1, 1'b0, 8'h05, 1'b1); cycle(); check("d1_rd0", 32'(b1.douta), 32'h0);
        drv1(1'b1, 1'b1, 8'h05, 1'b1); cycle(); check("d1_wr1b", 32'(b1.douta), 32'h1);
        drv1(1'b1, 1'b0, 8'h05, 1'b0); cycle(); check("d1_rd1b", 32'(b1.douta), 32'h1);
        drv1(1'b0, 1'b0, 8'h00, 1'b0);

        // ---------------- randomized against reference model ----------------
        for (int i = 0; i < 256; i++) begin
            if (i < 8'h40 || i > 8'h4F) ref_mem[i] = ref_mem[i];
        end
        ref_mem[8'h12] = 32'hAA22_CC44;
        ref_mem[8'h13] = 32'h0BAD_F00D;
        ref_dout       = 32'h0BAD_F00D;
        for (int a = 8'h40; a <= 8'h4F; a++) begin
            op32($sformatf("prefill%0h", a), 1'b1, 4'hF, 8'(a), $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            op32($sformatf("rand%0d", i),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 8'h40 + 8'($urandom_range(0, 15)),
                 $urandom);
        end

        // ---------------- async reset during a write ----------------
        op32("pre_rst_wr20", 1'b1, 4'hF, 8'h20, 32'h55AA_55AA);
        drv21(1'b1, 1'b1, 8'h01, 21'h0ABCDE);
        drv1(1'b1, 1'b1, 8'h07, 1'b1);
        cycle();
        check("pre_rst_d21", 32'(b21.douta), 32'h0ABCDE);
        drv32(1'b1, 4'hF, 8'h20, 32'h1234_5678);
        drv21(1'b0, 1'b0, 8'h00, 21'h0);
        drv1(1'b0, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_douta32", b32.douta, 32'h0);
        check("midrst_douta21", 32'(b21.douta), 32'h0);
        check("midrst_douta1", 32'(b1.douta), 32'h0);
        cycle();
        check("midrst_hold", b32.douta, 32'h0);
        rst_n = 1'b1;
        drv32(1'b1, 4'h0, 8'h20, 32'h0);
`ifdef CACHE_SRAM_RESET_CLEAR_EN
        drv32(1'b0, 4'h0, 8'h20, 32'h0);
        wait_init(cnt);
        check("reinit_cycles", 32'(cnt), 32'd256);
        drv32(1'b1, 4'h0, 8'h20, 32'h0);
        cycle();
        check("post_rst_rd20", b32.douta, 32'h0);
`else
        cycle();
        check("post_rst_rd20", b32.douta, 32'h55AA_55AA);
`endif
        drv32(1'b0, 4'h0, 8'h00, 32'h0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_sram.md
Name: cache_sram

Overview:
- Generic single-port synchronous RAM with per-lane write enables; one instance per cache array.
- Used three ways inside the data cache:
  - dirty array: 1 bit × 256, replaces D
  - tag+valid array: 21 bits × 256, replaces TAGV
  - data bank: 32 bits × 256 with byte enables, replaces DATA
- Port shape matches the vendor block-RAM primitives (clka/ena/wea/addra/dina/douta), so existing instantiations swap over with parameter overrides only.

Parameters:
- DATA_W, 32, word width in bits; range 1..64.
- ADDR_W, 8, address width; depth = 2**ADDR_W, i.e. 256 cache lines at default.
- WE_W, 4, number of write-enable lanes.
  - DATA_W must be divisible by WE_W; lane k covers bits [k*DATA_W/WE_W +: DATA_W/WE_W].
  - D and TAGV configurations use WE_W=1.

Ports:
- clka, input, 1: clock; all activity on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- ena, input, 1: port enable; no read or write when low.
- wea, input, WE_W: per-lane write enable; qualified by ena.
- addra, input, ADDR_W: word address.
- dina, input, DATA_W: write data.
- douta, output, DATA_W: registered read data.
- init_done, output, 1: high when the array is usable (see Optional Feature).

Behaviour:
- Reset: rst low asynchronously clears douta to 0; array contents are not touched, except as described under Optional Feature.
- Read (ena=1, wea=0): douta = mem[addra] one rising edge after the request; latency exactly 1 cycle.
- Write (ena=1, any wea bit set): each enabled lane of mem[addra] takes the matching slice of dina; disabled lanes keep their old value.
- Write-first: in the same edge, douta gets the merged post-write word, i.e. new lanes plus old unwritten lanes.
- ena=0: no array access; douta holds its previous value indefinitely.
- Back-to-back accesses: each cycle is independent.
  - A read of an address written in the previous cycle returns the new data.
  - No forwarding is needed beyond the array itself.
- wea with ena=0: ignored.
- Out-of-range addresses are impossible, since depth is a power of two; addra wraps naturally.
- Reset asserted mid-operation: the write in flight at that edge is dropped and douta goes to 0.
- Reset deasserted: the first access is accepted on the first rising edge with rst high.
- X on addra while ena=0 must not corrupt contents.

Optional Feature:
- Macro: CACHE_SRAM_RESET_CLEAR_EN.
- Defined:
  - After rst is released, an internal clear engine writes 0 to addresses 0..2**ADDR_W-1, one per cycle (256 cycles at default).
  - init_done is 0 from reset until the cycle after the last clear write, then stays 1.
  - While init_done=0, ena/wea are ignored and douta stays 0.
  - Reset reasserted during clearing restarts the sweep from address 0.
  - The cache uses this to invalidate TAGV and dirty bits.
- Not defined:
  - No clear engine; init_done is constant 1.
  - Contents after power-up are undefined (X in simulation); the array is inferable as plain block RAM.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_SIZE=16, LINE_NUM=256, INDEX_LOG=8, OFFSET_LOG=2
  - TAGV_W=21 (20-bit tag + valid bit), DIRTY_W=1, WORD_W=32, BYTE_LANES=4
- Optional sub-module cache_sram_clear: address counter plus done flag, compiled only under CACHE_SRAM_RESET_CLEAR_EN.
- Array storage and lane merge stay in cache_sram.

Test Plan:
- Reset then read: pulse rst low; read addr 0x00 -> douta=0 after reset; with macro, init_done rises after 256 cycles and a read of addr 0x7F returns 0x00000000.
- Full write/readback: write 0xDEADBEEF, wea=4'hF, to addr 0x12, then read 0x12 -> douta=0xDEADBEEF one cycle after the read.
- Byte-lane merge: with 0xDEADBEEF stored at addr 0x12, write 0x11223344 with wea=4'b0101 -> same-edge douta=0xDE22BE44, and a later read returns 0xDE22BE44.
- Hold on disable: read addr 0x12, then ena=0 for 5 cycles with addra/dina toggling -> douta stays 0xDE22BE44; a later read confirms memory is unchanged.
- Narrow configs:
  - DATA_W=21, WE_W=1: write 0x1ABCDE to addr 0xFF, read back 0x1ABCDE; addr 0x00 is unaffected.
  - DATA_W=1: toggle bit at addr 0x05 -> readback tracks it.
- Async reset mid-write: assert rst between edges during a write to addr 0x20 -> douta=0 immediately; the write is dropped, so a later read of 0x20 returns the old value, or 0 with the macro.
